// File: rtl/codec_volume_writer.sv
// -----------------------------------------------------------------------------
// codec_volume_writer
//
// Write-only I2C master that pushes a headphone volume setting into the WM8731
// codec. Each accepted Go produces one 3-byte write:
//   B0 = DEV_ADDR, B1 = {REG_ADDR, 1'b1}, B2 = volume
// The constant 1 in B1 is the LRHPBOTH bit, so both channels are updated.
//
// Parameters
//   CLK_DIV   Clk cycles per SCL quarter-period (min 2)
//   DEV_ADDR  I2C write address byte, R/W bit included
//   REG_ADDR  7-bit codec register address
//
// Ports
//   Clk       system clock
//   Rst_n     asynchronous active-low reset
//   Go        single-cycle write request, volume sampled with it
//   volume    [7] zero-cross enable, [6:0] headphone volume code
//   Busy      transfer in progress or a second write queued
//   Done      one-cycle pulse at the end of every transfer
//   Ack_err   last transfer saw a NACK; held until the next START
//   I2C_SCLK  SCL, push-pull
//   I2C_SDAT  SDA, open-drain (drives 0 or releases)
// -----------------------------------------------------------------------------
module codec_volume_writer #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [7:0]  DEV_ADDR = 8'h34,
  parameter logic [6:0]  REG_ADDR = 7'h02
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Go,
  input  logic [7:0] volume,
  output logic       Busy,
  output logic       Done,
  output logic       Ack_err,
  output logic       I2C_SCLK,
  inout  wire        I2C_SDAT
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0] q_cnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_idx;
  logic [7:0]       vol_cur;
  logic [7:0]       vol_next;
  logic             pending;
  logic             ack_bit;
  logic             err_flag;
  logic [7:0]       cur_byte;
  logic             tx_bit;
  logic             tick;
  logic             slot_end;
  logic             start_entry;
  logic             sda_low;
  logic             sda_in;

  // The quarter tick and the end of a 4-quarter bit slot drive all timing.
  assign tick        = (q_cnt == DIV_W'(CLK_DIV - 1));
  assign slot_end    = tick && (qtr == 2'd3);
  assign start_entry = (state_next == ST_START) && (state != ST_START);

  // SDA is open-drain: only ever pull low or release.
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
  assign sda_in   = I2C_SDAT;

  // Byte being shifted out, selected by position in the 3-byte frame.
  always_comb begin
    cur_byte = DEV_ADDR;
    case (byte_idx)
      2'd1:    cur_byte = {REG_ADDR, 1'b1};
      2'd2:    cur_byte = vol_cur;
      default: cur_byte = DEV_ADDR;
    endcase
  end

  assign tx_bit = cur_byte[bit_cnt];

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a NACK cuts the frame short and goes straight to STOP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (Go) state_next = ST_START;
      ST_START: if (slot_end) state_next = ST_BYTE;
      ST_BYTE:  if (slot_end && (bit_cnt == 3'd0)) state_next = ST_ACK;
      ST_ACK: begin
        if (slot_end) begin
          if (ack_bit || (byte_idx == 2'd2)) state_next = ST_STOP;
          else                               state_next = ST_BYTE;
        end
      end
      ST_STOP:  if (slot_end) state_next = ST_DONE;
      ST_DONE:  state_next = (pending || Go) ? ST_START : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bus and status outputs. START pulls SDA low in q1 while SCL is still high;
  // STOP raises SCL at q2 and releases SDA at q3.
  always_comb begin
    I2C_SCLK = 1'b1;
    sda_low  = 1'b0;
    Done     = 1'b0;
    Busy     = 1'b1;
    case (state)
      ST_IDLE:  Busy = 1'b0;
      ST_START: begin
        I2C_SCLK = (qtr < 2'd2);
        sda_low  = (qtr != 2'd0);
      end
      ST_BYTE: begin
        I2C_SCLK = qtr[1];
        sda_low  = ~tx_bit;
      end
      ST_ACK:   I2C_SCLK = qtr[1];
      ST_STOP: begin
        I2C_SCLK = qtr[1];
        sda_low  = (qtr != 2'd3);
      end
      ST_DONE: begin
        Done = 1'b1;
        Busy = pending;
      end
      default:  Busy = 1'b0;
    endcase
  end

  // Slot timing, bit/byte counters, ACK sampling and error reporting.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_cnt    <= '0;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      ack_bit  <= 1'b0;
      err_flag <= 1'b0;
      Ack_err  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) || (state == ST_DONE)) begin
        q_cnt <= '0;
        qtr   <= 2'd0;
      end else if (tick) begin
        q_cnt <= '0;
        qtr   <= qtr + 2'd1;
      end else begin
        q_cnt <= q_cnt + DIV_W'(1);
      end

      if (state != ST_BYTE) begin
        bit_cnt <= 3'd7;
      end else if (slot_end) begin
        bit_cnt <= bit_cnt - 3'd1;
      end

      if (start_entry) begin
        byte_idx <= 2'd0;
        err_flag <= 1'b0;
        Ack_err  <= 1'b0;
      end else begin
        if ((state == ST_ACK) && slot_end) begin
          byte_idx <= byte_idx + 2'd1;
          if (ack_bit) err_flag <= 1'b1;
        end
        if ((state == ST_STOP) && slot_end) begin
          Ack_err <= err_flag;
        end
      end

      // SCL rises at the start of q2; that is the moment the ACK is taken.
      if ((state == ST_ACK) && tick && (qtr == 2'd1)) begin
        ack_bit <= sda_in;
      end
    end
  end

  // Volume capture and the depth-1 request queue. The active frame keeps its
  // own copy so a late Go cannot corrupt bytes already on the wire.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vol_cur  <= 8'h00;
      vol_next <= 8'h00;
      pending  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Go) vol_cur <= volume;
        end
        ST_DONE: begin
          if (Go) begin
            vol_cur <= volume;
            pending <= 1'b0;
          end else if (pending) begin
            vol_cur <= vol_next;
            pending <= 1'b0;
          end
        end
        default: begin
          if (Go) begin
            vol_next <= volume;
            pending  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codec_volume_writer.sv
// -----------------------------------------------------------------------------
// tb_codec_volume_writer
//
// Directed bench for codec_volume_writer with CLK_DIV=2. A small I2C slave
// model decodes START/STOP and bytes off the bus, ACKs or NACKs on request
// and counts framing errors.
// -----------------------------------------------------------------------------
module tb_codec_volume_writer;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Go = 1'b0;
  logic [7:0] volume = 8'h00;
  logic       Busy;
  logic       Done;
  logic       Ack_err;
  logic       scl;
  wire        sda_bus;
  logic       slave_low = 1'b0;

  int errors = 0;
  int checks = 0;

  // Slave model state.
  int         nack_idx = -1;
  logic       prev_scl;
  logic       prev_sda;
  int         bitpos;
  logic [7:0] shreg;
  int         ack_phase;
  logic       bus_busy;
  int         byte_in_txn;
  int         start_cnt;
  int         stop_cnt;
  int         rx_cnt;
  int         proto_err;
  logic [7:0] rx_bytes [0:63];

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  codec_volume_writer #(
    .CLK_DIV (2),
    .DEV_ADDR(8'h34),
    .REG_ADDR(7'h02)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Go      (Go),
    .volume  (volume),
    .Busy    (Busy),
    .Done    (Done),
    .Ack_err (Ack_err),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus)
  );

  always #5 Clk = ~Clk;

  // Slave model sampled on the falling Clk edge, away from DUT updates.
  // A STOP's own SCL pulse is clocked in as a phantom bit, hence bitpos==1.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_scl    <= 1'b1;
      prev_sda    <= 1'b1;
      bitpos      <= 0;
      shreg       <= 8'h00;
      ack_phase   <= 0;
      bus_busy    <= 1'b0;
      byte_in_txn <= 0;
      start_cnt   <= 0;
      stop_cnt    <= 0;
      rx_cnt      <= 0;
      proto_err   <= 0;
      slave_low   <= 1'b0;
    end else begin
      prev_scl <= scl;
      prev_sda <= sda_bus;
      if ((sda_bus !== 1'b0) && (sda_bus !== 1'b1)) proto_err <= proto_err + 1;
      if (prev_scl && scl && prev_sda && !sda_bus) begin
        if (bus_busy) proto_err <= proto_err + 1;
        bus_busy    <= 1'b1;
        start_cnt   <= start_cnt + 1;
        bitpos      <= 0;
        byte_in_txn <= 0;
        ack_phase   <= 0;
      end else if (prev_scl && scl && !prev_sda && sda_bus) begin
        if (!bus_busy || (bitpos != 1) || (ack_phase != 0)) proto_err <= proto_err + 1;
        bus_busy <= 1'b0;
        stop_cnt <= stop_cnt + 1;
        bitpos   <= 0;
      end else if (!prev_scl && scl) begin
        if (ack_phase == 2) begin
          ack_phase <= 3;
        end else if (bus_busy && (ack_phase == 0)) begin
          shreg <= {shreg[6:0], sda_bus};
          if (bitpos == 7) begin
            rx_bytes[rx_cnt] <= {shreg[6:0], sda_bus};
            rx_cnt    <= rx_cnt + 1;
            bitpos    <= 0;
            ack_phase <= 1;
          end else begin
            bitpos <= bitpos + 1;
          end
        end
      end else if (prev_scl && !scl) begin
        if (ack_phase == 1) begin
          slave_low <= (byte_in_txn != nack_idx);
          ack_phase <= 2;
        end else if (ack_phase == 3) begin
          slave_low   <= 1'b0;
          ack_phase   <= 0;
          byte_in_txn <= byte_in_txn + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle Go; returns at the first falling edge inside START.
  task automatic applyStimulus(input logic [7:0] vol);
    @(negedge Clk);
    Go     = 1'b1;
    volume = vol;
    @(negedge Clk);
    Go     = 1'b0;
  endtask

  task automatic waitDone(input int bound, output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && (lat < bound)) begin
      @(negedge Clk);
      lat++;
      if (Done) seen = 1'b1;
    end
  endtask

  initial begin
    int   lat;
    logic seen;
    int   rx0;
    int   st0;
    int   sp0;
    int   done_cnt;
    int   busy_gap;
    int   cyc;

    // 1: reset state
    repeat (2) @(negedge Clk);
    checkOutput("rst_scl", scl, 1);
    checkOutput("rst_sda", sda_bus, 1);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_ackerr", Ack_err, 0);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("idle_scl", scl, 1);
    checkOutput("idle_busy", Busy, 0);

    // 2: full ACKed write of 0xC3
    rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
    applyStimulus(8'hC3);
    checkOutput("t2_busy_start", Busy, 1);
    waitDone(400, lat, seen);
    checkOutput("t2_done_seen", seen, 1);
    checkOutput("t2_latency", lat, 232);
    checkOutput("t2_ackerr", Ack_err, 0);
    checkOutput("t2_busy_at_done", Busy, 0);
    checkOutput("t2_nbytes", rx_cnt - rx0, 3);
    checkOutput("t2_b0", rx_bytes[rx0], 8'h34);
    checkOutput("t2_b1", rx_bytes[rx0 + 1], 8'h05);
    checkOutput("t2_b2", rx_bytes[rx0 + 2], 8'hC3);
    checkOutput("t2_starts", start_cnt - st0, 1);
    checkOutput("t2_stops", stop_cnt - sp0, 1);
    @(negedge Clk);
    checkOutput("t2_done_pulse", Done, 0);

    // 3: NACK on the address byte, then a clean write clears Ack_err
    nack_idx = 0;
    rx0 = rx_cnt; sp0 = stop_cnt;
    applyStimulus(8'h5A);
    waitDone(400, lat, seen);
    checkOutput("t3_done_seen", seen, 1);
    checkOutput("t3_latency", lat, 88);
    checkOutput("t3_ackerr", Ack_err, 1);
    checkOutput("t3_nbytes", rx_cnt - rx0, 1);
    checkOutput("t3_b0", rx_bytes[rx0], 8'h34);
    checkOutput("t3_stops", stop_cnt - sp0, 1);
    repeat (5) @(negedge Clk);
    checkOutput("t3_ackerr_held", Ack_err, 1);
    nack_idx = -1;
    applyStimulus(8'h11);
    checkOutput("t3_ackerr_clr", Ack_err, 0);
    waitDone(400, lat, seen);
    checkOutput("t3b_latency", lat, 232);
    checkOutput("t3b_ackerr", Ack_err, 0);

    // 4: two Go pulses during a transfer collapse into one extra write
    rx0 = rx_cnt; st0 = start_cnt;
    applyStimulus(8'hB2);
    repeat (40) @(negedge Clk);
    applyStimulus(8'h00);
    repeat (30) @(negedge Clk);
    applyStimulus(8'hF0);
    done_cnt = 0; busy_gap = 0; cyc = 0;
    while ((done_cnt < 2) && (cyc < 1000)) begin
      @(negedge Clk);
      cyc++;
      if (Done) done_cnt++;
      if ((done_cnt < 2) && !Busy) busy_gap++;
    end
    checkOutput("t4_done_pulses", done_cnt, 2);
    checkOutput("t4_busy_gap", busy_gap, 0);
    checkOutput("t4_starts", start_cnt - st0, 2);
    checkOutput("t4_nbytes", rx_cnt - rx0, 6);
    checkOutput("t4_w1_b2", rx_bytes[rx0 + 2], 8'hB2);
    checkOutput("t4_w2_b0", rx_bytes[rx0 + 3], 8'h34);
    checkOutput("t4_w2_b2", rx_bytes[rx0 + 5], 8'hF0);
    repeat (5) @(negedge Clk);
    checkOutput("t4_idle_busy", Busy, 0);
    checkOutput("proto_pre_reset", proto_err, 0);

    // 5: reset during B1, then a clean write
    applyStimulus(8'h77);
    repeat (100) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("t5_scl", scl, 1);
    checkOutput("t5_sda", sda_bus, 1);
    checkOutput("t5_busy", Busy, 0);
    checkOutput("t5_done", Done, 0);
    checkOutput("t5_ackerr", Ack_err, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    rx0 = rx_cnt;
    applyStimulus(8'h3C);
    waitDone(400, lat, seen);
    checkOutput("t5_latency", lat, 232);
    checkOutput("t5_b0", rx_bytes[rx0], 8'h34);
    checkOutput("t5_b1", rx_bytes[rx0 + 1], 8'h05);
    checkOutput("t5_b2", rx_bytes[rx0 + 2], 8'h3C);
    checkOutput("t5_ackerr_end", Ack_err, 0);
    repeat (4) @(negedge Clk);
    checkOutput("proto_final", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
